// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT byte responder and its handshake FSM.
//   - Register offsets inside the 32-byte decode window.
//   - Handshake FSM state encoding.
//   - mtimecmp reset value (all ones, so no timer interrupt fires after reset).
//   - Decoded request struct passed around the top.
package clint_pkg;

  localparam int WINDOW_BITS = 5;

  localparam logic [WINDOW_BITS-1:0] MSIP_OFF     = 5'h00;
  localparam logic [WINDOW_BITS-1:0] MTIMECMP_OFF = 5'h08;
  localparam logic [WINDOW_BITS-1:0] MTIME_OFF    = 5'h10;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } busState_t;

  // Write wins when both strobes are high, so only the write flag is carried.
  typedef struct packed {
    logic                   wr;
    logic [WINDOW_BITS-1:0] off;
  } busReq_t;

  // True when the offset falls in the 8-byte bank that starts at bankOff.
  function automatic logic inBank(input logic [WINDOW_BITS-1:0] off,
                                  input logic [WINDOW_BITS-1:0] bankOff);
    return off[WINDOW_BITS-1:3] == bankOff[WINDOW_BITS-1:3];
  endfunction

endpackage

// File: rtl/bus_wait_responder.sv
// Target-side handshake FSM for the byte bus: IDLE -> WAIT -> ACK -> DONE.
// A hit leaves IDLE, WAIT_CYCLES wait states follow, then ack is high for
// exactly one cycle (the edge closing that cycle is the commit edge). DONE
// holds until the core drops both strobes, preventing a second ack.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   hit        - in-window request present
//   reqActive  - any request strobe high (window ignored)
//   ack        - one-cycle completion / commit strobe
module bus_wait_responder
  import clint_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic reqActive,
  output logic ack
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  busState_t  state, stateNext;
  logic [3:0] waitCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= (state == ST_WAIT) ? waitCnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: if (hit) stateNext = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (waitCnt == WAIT_LAST) stateNext = ST_ACK;
      ST_ACK:  stateNext = ST_DONE;
      ST_DONE: if (!reqActive) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    ack = (state == ST_ACK);
  end

endmodule

// File: rtl/clint_byte_responder.sv
// CLINT-style timer block on the core's byte-wide data bus.
// Holds the 64-bit mtime counter, 64-bit mtimecmp and the msip bit, and
// drives the core's machine timer / software interrupt inputs.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   readMem, writeMem         - request strobes, held until memDataReady
//   addressBus[31:0]          - byte address, decoded against BASE_ADDR
//   dataBusIn[7:0]            - write data
//   dataBusOut[7:0]           - read data, non-zero only during a read ack
//   memDataReady              - one-cycle ack for in-window accesses
//   machineTimerInterrupt     - registered (mtime >= mtimecmp)
//   machineSoftwareInterrupt  - msip bit
module clint_byte_responder
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readMem,
  input  logic        writeMem,
  input  logic [31:0] addressBus,
  input  logic [7:0]  dataBusIn,
  output logic [7:0]  dataBusOut,
  output logic        memDataReady,
  output logic        machineTimerInterrupt,
  output logic        machineSoftwareInterrupt
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  busReq_t          req;
  logic             hit, ack, commit, readAck, tick;
  logic             isMsip, isCmp, isTime;
  logic [2:0]       byteSel;
  logic [5:0]       bitSel;
  logic [63:0]      mtime, mtimecmp, timeView;
  logic [55:0]      shadow;
  logic             msip, mtip;
  logic [PSC_W-1:0] psc;
  logic [7:0]       readByte;

  assign req     = '{wr: writeMem, off: addressBus[WINDOW_BITS-1:0]};
  assign hit     = (readMem | writeMem) &&
                   (addressBus[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
  assign byteSel = req.off[2:0];
  assign bitSel  = {byteSel, 3'b000};
  assign isMsip  = (req.off == MSIP_OFF);
  assign isCmp   = inBank(req.off, MTIMECMP_OFF);
  assign isTime  = inBank(req.off, MTIME_OFF);

  bus_wait_responder #(.WAIT_CYCLES(WAIT_CYCLES)) uWait (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .reqActive (readMem | writeMem),
    .ack       (ack)
  );

  assign commit  = ack & req.wr;
  assign readAck = ack & ~req.wr;
  assign tick    = (psc == PSC_LAST);

  // Byte 0 of mtime is live; bytes 1-7 come from the snapshot taken when
  // byte 0 was read, so a multi-byte read never tears across a carry.
  assign timeView = {shadow, mtime[7:0]};

  always_comb begin
    readByte = 8'h00;
    if (isMsip)      readByte = {7'b0, msip};
    else if (isCmp)  readByte = mtimecmp[bitSel +: 8];
    else if (isTime) readByte = timeView[bitSel +: 8];
  end

  assign dataBusOut               = readAck ? readByte : 8'h00;
  assign memDataReady             = ack;
  assign machineTimerInterrupt    = mtip;
  assign machineSoftwareInterrupt = msip;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= 64'd0;
      mtimecmp <= MTIMECMP_RESET;
      msip     <= 1'b0;
      psc      <= '0;
      shadow   <= 56'd0;
      mtip     <= 1'b0;
    end else begin
      // Prescaler free-runs; a byte write to mtime only drops that cycle's step.
      psc <= tick ? '0 : psc + 1'b1;
      if (commit && isTime)  mtime[bitSel +: 8] <= dataBusIn;
      else if (tick)         mtime <= mtime + 64'd1;
      if (commit && isCmp)   mtimecmp[bitSel +: 8] <= dataBusIn;
      if (commit && isMsip)  msip <= dataBusIn[0];
      if (readAck && isTime && byteSel == 3'd0) shadow <= mtime[63:8];
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_clint_byte_responder.sv
module tb_clint_byte_responder;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int W = 1;
  localparam int P = 1;

  logic        clk = 1'b0;
  logic        rst, readMem, writeMem;
  logic [31:0] addressBus;
  logic [7:0]  dataBusIn, dataBusOut;
  logic        memDataReady, mti, msi;

  always #5 clk = ~clk;

  clint_byte_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .PRESCALE(P)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .readMem                  (readMem),
    .writeMem                 (writeMem),
    .addressBus               (addressBus),
    .dataBusIn                (dataBusIn),
    .dataBusOut               (dataBusOut),
    .memDataReady             (memDataReady),
    .machineTimerInterrupt    (mti),
    .machineSoftwareInterrupt (msi)
  );

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: register contents as plain integers, advanced once per clock.
  logic [63:0] mMtime, mCmp;
  logic [63:0] mSnap = 64'd0;
  logic        mMsip, mMti;
  int          mPsc;
  logic        mWrEn = 1'b0;
  logic [4:0]  mWrOff = 5'd0;
  logic [7:0]  mWrData = 8'd0;
  logic        monEn = 1'b0;

  function automatic logic [63:0] setByte(input logic [63:0] v, input int i, input logic [7:0] b);
    logic [63:0] m;
    m = 64'hFF << (8 * i);
    return (v & ~m) | ({56'd0, b} << (8 * i));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mMtime <= 64'd0; mCmp <= '1; mMsip <= 1'b0; mMti <= 1'b0; mPsc <= 0;
    end else begin
      mMti <= (mMtime >= mCmp);
      mPsc <= (mPsc + 1) % P;
      if (mWrEn && mWrOff >= 16 && mWrOff <= 23) mMtime <= setByte(mMtime, int'(mWrOff) - 16, mWrData);
      else if (mPsc == P - 1)                    mMtime <= mMtime + 64'd1;
      if (mWrEn && mWrOff >= 8 && mWrOff <= 15)  mCmp <= setByte(mCmp, int'(mWrOff) - 8, mWrData);
      if (mWrEn && mWrOff == 0)                  mMsip <= mWrData[0];
    end
  end

  always @(negedge clk) begin
    if (monEn) begin
      chk("mtip level", mti, mMti);
      chk("msip level", msi, mMsip);
    end
  end

  function automatic logic [7:0] expRead(input logic [4:0] off);
    int o;
    o = int'(off);
    if (o == 0) return {7'b0, mMsip};
    if (o >= 8 && o <= 15) return 8'(mCmp >> (8 * (o - 8)));
    if (o == 16) return mMtime[7:0];
    if (o >= 17 && o <= 23) return 8'(mSnap >> (8 * (o - 16)));
    return 8'h00;
  endfunction

  // mode: 0 read, 1 write, 2 both strobes (write should win).
  task automatic xfer(input logic [31:0] addr, input int mode, input logic [7:0] wd,
                      input int hold, input string nm, output logic [7:0] rd);
    readMem = (mode != 1); writeMem = (mode != 0); addressBus = addr; dataBusIn = wd;
    rd = 8'h00;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      if (k < W) chk({nm, " wait"}, memDataReady, 0);
      else begin
        chk({nm, " ack"}, memDataReady, 1);
        rd = dataBusOut;
        if (mode == 0) begin
          chk({nm, " rdata"}, rd, expRead(addr[4:0]));
          if (addr[4:0] == 5'h10) mSnap = mMtime;
        end else begin
          mWrEn = 1'b1; mWrOff = addr[4:0]; mWrData = wd;
        end
      end
    end
    @(negedge clk);
    mWrEn = 1'b0;
    chk({nm, " single"}, memDataReady, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold"}, memDataReady, 0);
    end
    readMem = 1'b0; writeMem = 1'b0;
    @(negedge clk);
    chk({nm, " idle"}, memDataReady, 0);
  endtask

  // Low byte first so no carry from the counting byte lands mid-sequence.
  task automatic writeMtime(input logic [63:0] v);
    logic [7:0] rd;
    xfer(BASE + 32'h10, 1, 8'h00, 0, "mtime wr", rd);
    for (int b = 7; b >= 1; b--) xfer(BASE + 32'h10 + b, 1, v[b*8 +: 8], 0, "mtime wr", rd);
    xfer(BASE + 32'h10, 1, v[7:0], 0, "mtime wr", rd);
  endtask

  typedef struct {
    int         mode;
    logic [4:0] off;
    logic [7:0] wd;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int n;
    tbl[0]  = '{0, 5'h00, 8'h00, 3, 8'h00};
    tbl[1]  = '{1, 5'h00, 8'h01, 0, 8'h00};
    tbl[2]  = '{0, 5'h00, 8'h00, 0, 8'h01};
    tbl[3]  = '{1, 5'h00, 8'hFE, 0, 8'h00};
    tbl[4]  = '{0, 5'h00, 8'h00, 0, 8'h00};
    tbl[5]  = '{2, 5'h00, 8'h01, 0, 8'h00};
    tbl[6]  = '{0, 5'h00, 8'h00, 0, 8'h01};
    tbl[7]  = '{1, 5'h00, 8'h00, 0, 8'h00};
    tbl[8]  = '{1, 5'h0C, 8'hAB, 0, 8'h00};
    tbl[9]  = '{0, 5'h0C, 8'h00, 0, 8'hAB};
    tbl[10] = '{0, 5'h0B, 8'h00, 0, 8'hFF};
    tbl[11] = '{0, 5'h04, 8'h00, 0, 8'h00};
    tbl[12] = '{1, 5'h1C, 8'h55, 0, 8'h00};
    tbl[13] = '{0, 5'h1C, 8'h00, 0, 8'h00};
    tbl[14] = '{1, 5'h0C, 8'hFF, 1, 8'h00};

    // Reset with an in-window read pending: nothing may respond.
    rst = 1'b1; readMem = 1'b1; writeMem = 1'b0; addressBus = BASE; dataBusIn = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst ready", memDataReady, 0);
      chk("rst dout", dataBusOut, 0);
      chk("rst mtip", mti, 0);
      chk("rst msip", msi, 0);
    end
    rst = 1'b0; readMem = 1'b0;
    monEn = 1'b1;
    repeat (10) @(negedge clk);
    // 10 idle ticks plus W+1 cycles of latency before the ack cycle.
    xfer(BASE + 32'h10, 0, 8'h00, 0, "mtime10", rd);
    chk("mtime10 value", rd, 8'd12);
    xfer(BASE + 32'h11, 0, 8'h00, 0, "mtime10 b1", rd);
    chk("mtime10 b1 value", rd, 8'd0);

    foreach (tbl[i]) begin
      xfer(BASE + {27'd0, tbl[i].off}, tbl[i].mode, tbl[i].wd, tbl[i].hold, "tbl", rd);
      if (tbl[i].mode == 0) chk("tbl expect", rd, tbl[i].exp);
      else if (tbl[i].off == 5'h00) chk("tbl msip out", msi, tbl[i].wd[0]);
    end

    // Timer compare: mtimecmp = 0x20, then restart mtime from 0.
    xfer(BASE + 32'h08, 1, 8'h20, 0, "cmp wr", rd);
    for (int b = 1; b < 8; b++) xfer(BASE + 32'h08 + b, 1, 8'h00, 0, "cmp wr", rd);
    writeMtime(64'd0);
    chk("mtip low", mti, 0);
    n = 0;
    while (!mti && n < 100) begin @(negedge clk); n++; end
    chk("mtip rise", mti, 1);
    chk("mtip rise time", mMtime, 64'h21);
    for (int i = 0; i < 20; i++) begin @(negedge clk); chk("mtip stays", mti, 1); end
    xfer(BASE + 32'h0F, 1, 8'h01, 0, "cmp raise", rd);
    chk("mtip clear", mti, 0);

    // Tearing guard: spec value first, then one that carries mid-readout.
    writeMtime(64'h0000_0000_FFFF_FFFF);
    xfer(BASE + 32'h10, 0, 8'h00, 0, "tear0 b0", rd);
    xfer(BASE + 32'h14, 0, 8'h00, 0, "tear0 b4", rd);
    chk("tear0 b4 value", rd, 8'h01);
    writeMtime(64'h0000_0000_FFFF_FFE8);
    xfer(BASE + 32'h10, 0, 8'h00, 0, "tear b0", rd);
    repeat (5) @(negedge clk);
    for (int b = 1; b < 8; b++) begin
      xfer(BASE + 32'h10 + b, 0, 8'h00, 0, "tear bn", rd);
      chk("tear snapshot", rd, (b < 4) ? 8'hFF : 8'h00);
    end
    xfer(BASE + 32'h10, 0, 8'h00, 0, "tear again b0", rd);
    xfer(BASE + 32'h14, 0, 8'h00, 0, "tear again b4", rd);
    chk("tear carried", rd, 8'h01);

    // Off-window request, read then write, aimed at an msip alias.
    readMem = 1'b1; writeMem = 1'b0; addressBus = BASE + 32'h40; dataBusIn = 8'h01;
    for (int i = 0; i < 20; i++) begin
      writeMem = (i >= 10);
      @(negedge clk);
      chk("offwin ready", memDataReady, 0);
      chk("offwin dout", dataBusOut, 0);
    end
    readMem = 1'b0; writeMem = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      xfer(BASE + 32'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 8'($urandom),
           int'($urandom_range(0, 2)), "rand", rd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during WAIT aborts the transaction; FSM must be usable afterwards.
    readMem = 1'b0; writeMem = 1'b1; addressBus = BASE + 32'h08; dataBusIn = 8'h00;
    @(negedge clk);
    chk("rstwait ready", memDataReady, 0);
    rst = 1'b1; writeMem = 1'b0; mSnap = 64'd0;
    @(negedge clk);
    chk("rstwait abort", memDataReady, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("rstwait idle", memDataReady, 0); end
    xfer(BASE + 32'h08, 0, 8'h00, 0, "rstwait cmp", rd);
    chk("rstwait no write", rd, 8'hFF);
    xfer(BASE + 32'h00, 0, 8'h00, 0, "rstwait msip", rd);

    monEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
